snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game sequencer for the VGA snake game. Generates the snake move tick and commits player
//  direction once per move. Runs the game FSM (idle/init/run/over) and keeps the score.
//  Sits beside the snake/apple datapath; the datapath moves one cell per step and reports hits.
// PARAMETERS
//  STEP_DIV  10_000_000  clk50 cycles between move steps (initial period)
//  MIN_DIV   2_000_000   floor of step period (SNAKE_SPEEDUP_EN only)
//  DIV_DEC   500_000     period decrement per apple eaten (SNAKE_SPEEDUP_EN only)
//  SCORE_W   8           score counter width
// PORTS
//  clk50      in   1        system clock
//  reset_n    in   1        asynchronous, active-low reset
//  up         in   1        button, async level
//  down       in   1        button, async level
//  left       in   1        button, async level
//  right      in   1        button, async level
//  start      in   1        start/restart button, async level
//  wall_hit   in   1        datapath: head on border or body, sync to clk50
//  apple_hit  in   1        datapath: one-cycle pulse per apple eaten
//  step       out  1        one-cycle move pulse to datapath
//  dir        out  2        committed direction: 0 right, 1 down, 2 left, 3 up
//  init       out  1        one-cycle pulse: datapath loads initial snake/apples
//  state      out  2        0 IDLE, 1 INIT, 2 RUN, 3 OVER
//  game_over  out  1        high in OVER (datapath blanks display)
//  score      out  SCORE_W  apples eaten, saturating
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; step=0; init=0; dir=0; pending=0; timer=0;
//    score=0; game_over=0; period=STEP_DIV; synchronizers cleared.
//  Inputs up/down/left/right/start: 2-FF synchronizers. start is rising-edge detected
//    after sync, so edge-to-action latency is 3 cycles.
//  Arbitration, every cycle in RUN:
//    - pick the highest-priority pressed button: up > left > down > right.
//    - if it is the reverse of committed dir, the cycle is ignored (lower buttons not considered).
//    - otherwise pending <= its code. No button pressed: pending holds.
//  FSM:
//    IDLE: start edge -> INIT.
//    INIT: exactly 1 cycle, init=1. Clears dir/pending/timer/score and sets period=STEP_DIV.
//      Next state is RUN.
//    RUN: timer counts 0..period-1. At period-1: timer<=0, step=1 for that cycle, dir<=pending.
//      wall_hit=1 in any RUN cycle -> OVER next cycle. If this coincides with terminal count,
//      wall_hit wins: step not asserted, dir not updated.
//      apple_hit=1 -> score+1, saturating at 2^SCORE_W-1.
//      apple_hit and wall_hit in the same cycle: score increments, then OVER.
//    OVER: game_over=1, timer frozen, apple_hit/wall_hit ignored. start edge -> INIT.
//      Score holds until INIT.
//  start edge during RUN or INIT: ignored.
//  Timer width $clog2(STEP_DIV+1). Registered outputs; step/init are glitch-free pulses.
// CONFIGURATION
//  SNAKE_SPEEDUP_EN defined:
//    - each apple_hit in RUN sets period <= max(period-DIV_DEC, MIN_DIV).
//    - the new period takes effect from the next timer wrap, never mid-count.
//  Not defined:
//    - period is constant STEP_DIV; MIN_DIV and DIV_DEC are unused.
// STRUCTURE
//  Package snake_pkg: DIR_RIGHT/DOWN/LEFT/UP codes, state codes, reverse_dir function.
//    Shared with the snake datapath.
//  Sub-module snake_dir_arb: button synchronizers, priority/reverse rejection, pending register.
//  The FSM, timer and score stay in snake_game_ctrl.
// TESTING (STEP_DIV=16, SCORE_W=8 unless noted)
//  1 Reset: assert reset_n=0 mid-RUN -> state=0, step=0, dir=0, score=0, game_over=0
//    immediately, with no clock needed.
//  2 Start: start edge -> init high 1 cycle 3 cycles later, state=2; first step exactly
//    16 cycles after init, then every 16 cycles.
//  3 Direction: dir=0, press down -> dir=1 only at next step. dir=0, press left -> dir
//    stays 0. Press up+down with dir=1 -> ignored.
//  4 Collision: wall_hit on a terminal-count cycle -> no step, state=3, game_over=1.
//    start edge -> INIT, score=0.
//  5 Score: 300 apple_hit pulses -> score=255 and held. apple_hit with wall_hit same
//    cycle -> score+1 and state=3.
//  6 SNAKE_SPEEDUP_EN (STEP_DIV=16, DIV_DEC=4, MIN_DIV=8): step spacing is 16, then 12
//    after 1 apple, then 8 after 2 apples, and stays 8 after 5 apples.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared codes for the snake game: move directions, game states and direction reversal.
// Used by the game controller and the snake/apple datapath.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // Opposite directions differ only in the MSB of the code.
    function automatic logic [1:0] reverse_dir(input logic [1:0] i_d);
        return i_d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_dir_arb.sv
// Button synchronizers and direction arbitration: up > left > down > right, a reversing
// request blocks the whole cycle, and the winner is held in the pending register.
module snake_dir_arb
    import snake_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic [1:0] i_dir,
    output logic [1:0] o_pending
);

    logic [3:0] r_btn_s1;
    logic [3:0] r_btn_s2;
    logic [1:0] r_pending;
    logic       w_req;
    logic [1:0] w_code;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_btn_s1 <= {i_up, i_left, i_down, i_right};
            r_btn_s2 <= r_btn_s1;
        end
    end

    always_comb begin
        w_req  = 1'b1;
        w_code = DIR_RIGHT;
        if (r_btn_s2[3])      w_code = DIR_UP;
        else if (r_btn_s2[2]) w_code = DIR_LEFT;
        else if (r_btn_s2[1]) w_code = DIR_DOWN;
        else if (r_btn_s2[0]) w_code = DIR_RIGHT;
        else                  w_req  = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= DIR_RIGHT;
        end else if (i_clr) begin
            r_pending <= DIR_RIGHT;
        end else if (i_en && w_req && (w_code != reverse_dir(i_dir))) begin
            r_pending <= w_code;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move-step timer, direction commit, game FSM and saturating score.
// Optional build macro SNAKE_SPEEDUP_EN shortens the step period with every apple eaten.
//
// state | meaning
// IDLE  | after reset, waiting for a start edge
// INIT  | one cycle, datapath loads snake/apples, counters cleared
// RUN   | game running, steps issued every period cycles
// OVER  | collision seen, display blanked, waiting for a start edge
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int STEP_DIV = 10_000_000,
    parameter int MIN_DIV  = 2_000_000,
    parameter int DIV_DEC  = 500_000,
    parameter int SCORE_W  = 8
) (
    input  logic               clk50,
    input  logic               reset_n,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               start,
    input  logic               wall_hit,
    input  logic               apple_hit,
    output logic               step,
    output logic [1:0]         dir,
    output logic               init,
    output logic [1:0]         state,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    localparam int            TW          = $clog2(STEP_DIV + 1);
    localparam logic [TW-1:0] PERIOD_INIT = TW'(STEP_DIV);
    localparam logic [TW-1:0] ONE_T       = TW'(1);

    if (STEP_DIV < 2 || MIN_DIV < 2 || MIN_DIV > STEP_DIV || DIV_DEC < 0) begin : g_bad_cfg
        $error("snake_game_ctrl: step period parameters out of range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_s1;
    logic               r_start_s2;
    logic               r_start_d;
    logic               w_start_edge;
    logic [TW-1:0]      r_timer;
    logic [TW-1:0]      w_period;
    logic               w_tc;
    logic               w_enter_init;
    logic               w_step_nxt;
    logic               w_over_nxt;
    logic               r_step;
    logic               r_init;
    logic               r_game_over;
    logic [1:0]         r_dir;
    logic [1:0]         w_pending;
    logic [SCORE_W-1:0] r_score;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_d  <= 1'b0;
        end else begin
            r_start_s1 <= start;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
        end
    end

    assign w_start_edge = r_start_s2 & ~r_start_d;

    snake_dir_arb u_dir_arb (
        .i_clk     (clk50),
        .i_rst_n   (reset_n),
        .i_en      (r_state == ST_RUN),
        .i_clr     (w_enter_init),
        .i_up      (up),
        .i_down    (down),
        .i_left    (left),
        .i_right   (right),
        .i_dir     (r_dir),
        .o_pending (w_pending)
    );

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_step      <= 1'b0;
            r_init      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_init      <= w_enter_init;
            r_game_over <= w_over_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_edge) w_state_nxt = ST_INIT;
            ST_INIT: w_state_nxt = ST_RUN;
            ST_RUN:  if (wall_hit) w_state_nxt = ST_OVER;
            ST_OVER: if (w_start_edge) w_state_nxt = ST_INIT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A collision on the terminal-count cycle suppresses the step and the dir commit.
    always_comb begin
        w_enter_init = (w_state_nxt == ST_INIT);
        w_step_nxt   = w_tc & ~wall_hit;
        w_over_nxt   = (w_state_nxt == ST_OVER);
    end

    assign w_tc = (r_state == ST_RUN) && (r_timer == (w_period - ONE_T));

    // The INIT cycle counts as timer tick 0, so the first step lands one period after init.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (w_enter_init) begin
            r_timer <= '0;
        end else if (r_state == ST_INIT) begin
            r_timer <= r_timer + ONE_T;
        end else if ((r_state == ST_RUN) && !wall_hit) begin
            r_timer <= w_tc ? '0 : (r_timer + ONE_T);
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_dir <= DIR_RIGHT;
        end else if (w_enter_init) begin
            r_dir <= DIR_RIGHT;
        end else if (w_step_nxt) begin
            r_dir <= w_pending;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_score <= '0;
        end else if (w_enter_init) begin
            r_score <= '0;
        end else if ((r_state == ST_RUN) && apple_hit && (r_score != {SCORE_W{1'b1}})) begin
            r_score <= r_score + SCORE_W'(1);
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [TW-1:0] MIN_P = TW'(MIN_DIV);
    localparam logic [TW-1:0] DEC_P = TW'(DIV_DEC);

    logic [TW-1:0] r_period;
    logic [TW-1:0] r_period_pend;

    // Apples update the pending period; the live period only changes at a timer wrap.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_period      <= PERIOD_INIT;
            r_period_pend <= PERIOD_INIT;
        end else if (w_enter_init) begin
            r_period      <= PERIOD_INIT;
            r_period_pend <= PERIOD_INIT;
        end else begin
            if ((r_state == ST_RUN) && apple_hit) begin
                r_period_pend <= (r_period_pend > (MIN_P + DEC_P)) ? (r_period_pend - DEC_P) : MIN_P;
            end
            if (w_tc) begin
                r_period <= r_period_pend;
            end
        end
    end

    assign w_period = r_period;
`else
    assign w_period = PERIOD_INIT;
`endif

    assign step      = r_step;
    assign dir       = r_dir;
    assign init      = r_init;
    assign state     = r_state;
    assign game_over = r_game_over;
    assign score     = r_score;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: expected steps (dir, spacing) are queued by the
// stimulus and checked by a monitor whenever step pulses; state/score checked inline.
module tb_snake_game_ctrl;

    logic       clk50 = 1'b0;
    logic       reset_n;
    logic       up, down, left, right, start, wall_hit, apple_hit;
    logic       step;
    logic [1:0] dir;
    logic       init;
    logic [1:0] state;
    logic       game_over;
    logic [7:0] score;

    snake_game_ctrl #(
        .STEP_DIV (16),
        .MIN_DIV  (8),
        .DIV_DEC  (4),
        .SCORE_W  (8)
    ) dut (
        .clk50     (clk50),
        .reset_n   (reset_n),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .start     (start),
        .wall_hit  (wall_hit),
        .apple_hit (apple_hit),
        .step      (step),
        .dir       (dir),
        .init      (init),
        .state     (state),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk50 = ~clk50;

    typedef struct {
        logic [1:0] dir;
        int         gap;
    } step_exp_t;

    step_exp_t exp_q[$];
    int        cyc       = 0;
    int        n_vec     = 0;
    int        n_err     = 0;
    int        last_evt  = 0;
    int        t0        = 0;
    bit        chk_steps = 1'b1;

    always @(posedge clk50) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_step(input logic [1:0] d, input int gap);
        step_exp_t e;
        e.dir = d;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: every step pulse pops one expectation and checks dir and spacing.
    always @(negedge clk50) begin
        step_exp_t e;
        if (init) last_evt = cyc;
        if (step) begin
            if (chk_steps) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_step: step=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("step_dir", int'(dir), int'(e.dir));
                    check("step_gap", cyc - last_evt, e.gap);
                end
            end
            last_evt = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic wait_to(input int k);
        if (cyc > t0 + k) check("schedule", cyc, t0 + k);
        while (cyc < t0 + k) @(negedge clk50);
    endtask

    task automatic apple_pulse();
        apple_hit = 1'b1;
        tick(1);
        apple_hit = 1'b0;
    endtask

    task automatic do_start();
        int n;
        n = 0;
        start = 1'b1;
        while (!init && n < 8) begin
            tick(1);
            n++;
        end
        check("init_latency", n, 3);
        check("init_state", int'(state), 1);
        t0 = cyc;
        start = 1'b0;
        tick(1);
        check("run_state", int'(state), 2);
        check("init_width", int'(init), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        {up, down, left, right, start, wall_hit, apple_hit} = '0;
        tick(3);
        check("rst_state", int'(state), 0);
        check("rst_step", int'(step), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_init", int'(init), 0);
        check("rst_over", int'(game_over), 0);
        check("rst_score", int'(score), 0);
        reset_n = 1'b1;
        tick(4);
        check("idle_hold", int'(state), 0);

        // Game 1: score saturation, collision, OVER freezes everything.
        do_start();
        chk_steps = 1'b0;
        for (int i = 0; i < 300; i++) begin
            apple_pulse();
            tick(1);
        end
        check("score_sat", int'(score), 255);
        wall_hit = 1'b1;
        tick(1);
        wall_hit = 1'b0;
        check("over_state", int'(state), 3);
        check("over_flag", int'(game_over), 1);
        chk_steps = 1'b1;
        apple_pulse();
        tick(40);
        check("over_score_hold", int'(score), 255);
        check("over_stays", int'(state), 3);

        // Game 2: restart clears score, step timing, direction arbitration, wall on terminal count.
        do_start();
        check("restart_score", int'(score), 0);
        check("restart_dir", int'(dir), 0);
        check("restart_over", int'(game_over), 0);
        push_step(2'd0, 16);
        push_step(2'd0, 16);
        push_step(2'd0, 16);
        wait_to(50);  left = 1'b1;
        wait_to(58);  left = 1'b0;  push_step(2'd0, 16);
        wait_to(66);  down = 1'b1;
        wait_to(70);  down = 1'b0;  push_step(2'd1, 16);
        wait_to(74);  check("dir_before_step", int'(dir), 0);
        wait_to(81);  check("dir_after_step", int'(dir), 1);
        wait_to(82);  up = 1'b1; down = 1'b1;
        wait_to(88);  up = 1'b0; down = 1'b0;  push_step(2'd1, 16);
        wait_to(98);  right = 1'b1;
        wait_to(102); right = 1'b0;  push_step(2'd0, 16);
        wait_to(114); down = 1'b1;
        wait_to(118); down = 1'b0;
        wait_to(127); wall_hit = 1'b1;
        tick(1);
        wall_hit = 1'b0;
        check("tc_wall_step", int'(step), 0);
        check("tc_wall_state", int'(state), 3);
        check("tc_wall_over", int'(game_over), 1);
        check("tc_wall_dir", int'(dir), 0);
        tick(20);
        check("game2_steps_left", exp_q.size(), 0);

        // Game 3: apple and wall in the same cycle.
        do_start();
        wait_to(2); apple_pulse();
        wait_to(4); apple_pulse();
        wait_to(6); apple_pulse();
        wait_to(8);
        check("score_pre", int'(score), 3);
        apple_hit = 1'b1;
        wall_hit  = 1'b1;
        tick(1);
        apple_hit = 1'b0;
        wall_hit  = 1'b0;
        check("apple_wall_score", int'(score), 4);
        check("apple_wall_state", int'(state), 3);
        tick(5);

`ifdef SNAKE_SPEEDUP_EN
        // Game 4: period 16 -> 12 -> 8, floored at 8, changes only at a wrap.
        do_start();
        push_step(2'd0, 16);
        push_step(2'd0, 16);
        wait_to(18); apple_pulse();
        push_step(2'd0, 12);
        push_step(2'd0, 12);
        wait_to(46); apple_pulse();
        push_step(2'd0, 8);
        push_step(2'd0, 8);
        push_step(2'd0, 8);
        push_step(2'd0, 8);
        wait_to(66); apple_pulse();
        wait_to(68); apple_pulse();
        wait_to(70); apple_pulse();
        wait_to(90);
        check("speedup_score", int'(score), 5);
        wall_hit = 1'b1;
        tick(1);
        wall_hit = 1'b0;
        check("speedup_over", int'(state), 3);
        check("speedup_steps_left", exp_q.size(), 0);
        tick(5);
`endif

        // Game 5: asynchronous reset mid-RUN, outputs clear without a clock edge.
        do_start();
        push_step(2'd1, 16);
        wait_to(2);  down = 1'b1;
        wait_to(6);  down = 1'b0;
        wait_to(10); apple_pulse();
        wait_to(20);
        check("pre_rst_dir", int'(dir), 1);
        check("pre_rst_score", int'(score), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_step", int'(step), 0);
        check("arst_dir", int'(dir), 0);
        check("arst_score", int'(score), 0);
        check("arst_over", int'(game_over), 0);
        check("arst_init", int'(init), 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check("post_rst_state", int'(state), 0);
        check("steps_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
